right_shift_unit: RTL and testbench

- Multi-cycle right shifter for the datapath: the companion to the left-shift stage, covering ARM-style LSR, ASR, ROR and RRX.
- Shifts one bit position per clock and tracks the carry-out (last bit shifted out).
- Uses a start/busy/done handshake with the ALU control sequencer.
- Result and flags are registered and held until the next accepted start.

---
 rtl/right_shift_unit.sv | 105 ++++++++++
 tb/tb_right_shift_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/right_shift_unit.sv
// Multi-cycle right shifter (LSR/ASR/ROR/RRX), one bit position per clock,
// with carry-out tracking and a start/busy/done handshake.
`timescale 1ns/1ps
module right_shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  input  logic             carry_in,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {LSR = 2'b00, ASR = 2'b01, ROR = 2'b10, RRX = 2'b11} mode_t;

  state_t           state;
  mode_t            mode_q;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_next;
  logic [AMT_W-1:0] cnt;
  logic             c_q;
  logic             fill;

  // Bit entering at the MSB for one step; only the captured mode is decoded.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the block latch-free.
    fill = 1'b0;
    case (mode_q)
      LSR:     fill = 1'b0;
      ASR:     fill = w[WIDTH-1];
      ROR:     fill = w[0];
      RRX:     fill = c_q;
      default: fill = 1'b0;
    endcase
    w_next = {fill, w[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= LSR;
      w         <= '0;
      cnt       <= '0;
      c_q       <= 1'b0;
      y         <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (start) begin
            w      <= x;
            mode_q <= mode_t'(mode);
            c_q    <= carry_in;
            if (mode_t'(mode) == RRX) begin
              cnt   <= AMT_W'(1);
              state <= SHIFT;
              busy  <= 1'b1;
            end else if (amt == '0) begin
              // Zero-length shift completes immediately with the C flag passed through.
              state     <= DONE;
              y         <= x;
              carry_out <= carry_in;
              zero      <= (x == '0);
              done      <= 1'b1;
            end else begin
              cnt   <= amt;
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          w   <= w_next;
          c_q <= w[0];
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            y         <= w_next;
            carry_out <= w[0];
            zero      <= (w_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_right_shift_unit.sv
// Self-checking bench for right_shift_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_right_shift_unit;

  localparam int W = 16;
  localparam int A = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [A-1:0] amt = '0;
  logic [1:0]   mode = 2'b00;
  logic         carry_in = 1'b0;
  logic [W-1:0] y;
  logic         carry_out;
  logic         zero;
  logic         busy;
  logic         done;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_y = '0;
  logic         prev_c = 1'b0;

  right_shift_unit #(.WIDTH(W), .AMT_W(A)) dut (
    .clock(clock), .reset(reset), .start(start), .x(x), .amt(amt),
    .mode(mode), .carry_in(carry_in), .y(y), .carry_out(carry_out),
    .zero(zero), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: result and last bit shifted out, computed directly.
  function automatic void model(input logic [W-1:0] xv, input logic [A-1:0] a,
                                input logic [1:0] m, input logic c,
                                output logic [W-1:0] ry, output logic rc);
    int n;
    n = int'(a);
    if (m == 2'b11) begin
      ry = {c, xv[W-1:1]};
      rc = xv[0];
    end else if (n == 0) begin
      ry = xv;
      rc = c;
    end else begin
      rc = xv[n-1];
      case (m)
        2'b00:   ry = xv >> n;
        2'b01:   ry = W'($signed(xv) >>> n);
        default: ry = W'((xv >> n) | (xv << (W - n)));
      endcase
    end
  endfunction

  task automatic op(input logic [W-1:0] xv, input logic [A-1:0] a, input logic [1:0] m,
                    input logic c, input int pulse_at, input bit b2b);
    logic [W-1:0] ey;
    logic         ec;
    int           lat;
    int           cyc;
    model(xv, a, m, c, ey, ec);
    lat = (m == 2'b11) ? 2 : int'(a) + 1;
    if (!b2b) begin
      @(negedge clock);
      check("idle_done", 32'(done), 32'(0));
    end
    start = 1'b1; x = xv; amt = a; mode = m; carry_in = c;
    @(negedge clock);
    start = 1'b0;
    x = W'($urandom); amt = A'($urandom); mode = 2'($urandom); carry_in = 1'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      check("busy", 32'(busy), 32'(1));
      check("y_hold", 32'(y), 32'(prev_y));
      check("c_hold", 32'(carry_out), 32'(prev_c));
      start = (cyc == pulse_at);
      if (start) x = '1;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("y", 32'(y), 32'(ey));
    check("carry_out", 32'(carry_out), 32'(ec));
    check("zero", 32'(zero), 32'(ey == '0));
    check("busy_done", 32'(busy), 32'(0));
    prev_y = ey;
    prev_c = ec;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_y", 32'(y), 32'(0));
    check("rst_c", 32'(carry_out), 32'(0));
    check("rst_zero", 32'(zero), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    reset = 1'b0;

    op(16'h000B, 4'd1,  2'b00, 1'b0, 0, 1'b0);
    op(16'h8004, 4'd3,  2'b01, 1'b0, 0, 1'b0);
    op(16'hFFFF, 4'd15, 2'b00, 1'b0, 0, 1'b0);
    op(16'h0001, 4'd4,  2'b10, 1'b0, 0, 1'b0);
    op(16'h0003, 4'd7,  2'b11, 1'b1, 0, 1'b0);
    op(16'h1234, 4'd0,  2'b00, 1'b1, 0, 1'b0);
    op(16'h0001, 4'd1,  2'b00, 1'b0, 0, 1'b0);
    op(16'h00F0, 4'd8,  2'b00, 1'b0, 3, 1'b0);
    op(16'h8000, 4'd1,  2'b01, 1'b0, 0, 1'b1);

    // Reset in the middle of a ROR aborts it without a done pulse.
    @(negedge clock);
    start = 1'b1; x = 16'hA5C3; amt = 4'd10; mode = 2'b10; carry_in = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_y", 32'(y), 32'(0));
    check("abort_c", 32'(carry_out), 32'(0));
    check("abort_zero", 32'(zero), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    reset = 1'b0;
    prev_y = '0;
    prev_c = 1'b0;
    repeat (12) begin
      @(negedge clock);
      check("no_done_after_abort", 32'(done), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
    end
    op(16'hA5C3, 4'd10, 2'b10, 1'b1, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op(W'($urandom), A'($urandom), 2'($urandom), 1'($urandom), 0, ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
